// File: rtl/fir_mac_serial_pkg.sv
// Shared types and helpers for the serial FIR MAC filter (fir_mac_serial).
// Holds the FSM state encoding, pointer-width helper and the output saturation function.
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  // Width of a pointer that indexes n entries; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The caller truncates the result to w bits.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                       input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_serial_if.sv
// Sample-in / result-out bus of fir_mac_serial: valid/ready input handshake,
// packed coefficient word and the registered result with its valid pulse.
interface fir_mac_serial_if #(
  parameter int NB_IN     = 8,
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8,
  parameter int NB_OUT    = NB_IN + NB_COEFFS + $clog2(N_COEFFS)
);

  logic signed [NB_IN-1:0]            i_data;
  logic                               i_valid;
  logic                               o_ready;
  logic [NB_COEFFS*N_COEFFS-1:0]      i_coeffs;
  logic signed [NB_OUT-1:0]           o_data;
  logic                               o_valid;

  modport master (
    output i_data,
    output i_valid,
    output i_coeffs,
    input  o_ready,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_coeffs,
    output o_ready,
    output o_data,
    output o_valid
  );

endinterface

// File: rtl/fir_mac_serial_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
// sum_o is the value the accumulator takes at the next edge, so a caller can
// capture the final sum in the same cycle the last product is added.
module fir_mac_unit #(
  parameter int NB_A   = 8,
  parameter int NB_B   = 8,
  parameter int NB_ACC = 19
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [NB_A-1:0]   a_i,
  input  logic signed [NB_B-1:0]   b_i,
  output logic signed [NB_ACC-1:0] sum_o
);

  logic signed [NB_A+NB_B-1:0] prod;
  logic signed [NB_ACC-1:0]    acc_q;
  logic signed [NB_ACC-1:0]    acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + NB_ACC'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_d;

endmodule

// File: rtl/fir_mac_serial.sv
// Serial FIR filter: one MAC walks N_COEFFS taps over a circular delay line per sample.
// Optional output saturation is built when FIR_MAC_SERIAL_SAT_EN is defined.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | o_ready=1, waiting for a sample; accepts on i_valid
//   MAC   | o_ready=0, one tap per cycle; last tap loads the output register
module fir_mac_serial
  import fir_pkg::*;
#(
  parameter int NB_IN     = 8,
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8,
  parameter int NB_ACC    = NB_IN + NB_COEFFS + $clog2(N_COEFFS),
  parameter int NB_OUT    = NB_ACC
) (
  input  logic               i_clock,
  input  logic               i_rst_n,
  fir_mac_serial_if.slave    bus
);

  localparam int             PW   = ptr_width(N_COEFFS);
  localparam logic [PW-1:0]  LAST = PW'(N_COEFFS - 1);

  state_t                    state_q;
  state_t                    state_d;
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q;
  logic [PW-1:0]             rd_ptr_d;
  logic [PW-1:0]             tap_q;
  logic [PW-1:0]             tap_d;
  logic signed [NB_OUT-1:0]  out_q;
  logic signed [NB_OUT-1:0]  out_d;
  logic                      valid_q;
  logic                      valid_d;
  logic signed [NB_IN-1:0]   delay_q [N_COEFFS];

  logic                      accept;
  logic                      mac_clr;
  logic                      mac_en;
  logic                      ready;
  logic signed [NB_IN-1:0]   sample_k;
  logic signed [NB_COEFFS-1:0] coeff_k;
  logic signed [NB_ACC-1:0]  acc_nxt;
  logic signed [NB_OUT-1:0]  out_conv;

  assign sample_k = delay_q[rd_ptr_q];
  assign coeff_k  = bus.i_coeffs[int'(tap_q)*NB_COEFFS +: NB_COEFFS];

  fir_mac_unit #(
    .NB_A   (NB_IN),
    .NB_B   (NB_COEFFS),
    .NB_ACC (NB_ACC)
  ) u_mac (
    .clk_i   (i_clock),
    .rst_n_i (i_rst_n),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .a_i     (sample_k),
    .b_i     (coeff_k),
    .sum_o   (acc_nxt)
  );

`ifdef FIR_MAC_SERIAL_SAT_EN
  always_comb begin
    if (NB_OUT < NB_ACC) begin
      out_conv = NB_OUT'(sat_to_width(64'(acc_nxt), NB_OUT));
    end else begin
      out_conv = acc_nxt[NB_OUT-1:0];
    end
  end
`else
  assign out_conv = acc_nxt[NB_OUT-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tap_d    = tap_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    accept   = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.i_valid) begin
          accept   = 1'b1;
          mac_clr  = 1'b1;
          tap_d    = '0;
          rd_ptr_d = wr_ptr_q;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_en   = 1'b1;
        tap_d    = tap_q + 1'b1;
        // Read pointer walks backwards through history, wrapping explicitly
        // so non-power-of-two depths work.
        rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
        if (tap_q == LAST) begin
          state_d  = IDLE;
          tap_d    = '0;
          wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
          out_d    = out_conv;
          valid_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tap_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tap_q    <= tap_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_COEFFS; i++) begin
        delay_q[i] <= '0;
      end
    end else if (accept) begin
      delay_q[wr_ptr_q] <= bus.i_data;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_data  = out_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Scoreboard bench for fir_mac_serial: an 8-tap full-width instance and a
// 5-tap instance with a 12-bit output, both checked against a direct-form model.
module tb_fir_mac_serial;

  localparam int NA    = 8;
  localparam int NB    = 5;
  localparam int OA    = 19;
  localparam int OB    = 12;
  localparam int ACC_W = 19;

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  int   ca[$];
  int   cb[$];
  int   hist_a[$];
  int   hist_b[$];
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea;
  exp_t eb;
  exp_t pa;
  exp_t pb;
  longint last_a = 0;
  longint last_b = 0;
  int   busy_a = -100;
  int   busy_b = -100;
  int   acc_cnt_a = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_serial_if #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(NA), .NB_OUT(OA)) bus_a ();
  fir_mac_serial_if #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(NB), .NB_OUT(OB)) bus_b ();

  fir_mac_serial #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(NA), .NB_OUT(OA)) dut_a (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  fir_mac_serial #(.NB_IN(8), .NB_COEFFS(8), .N_COEFFS(NB), .NB_OUT(OB)) dut_b (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  // Direct-form reference: y[n] = sum c[k]*x[n-k], missing history is zero,
  // then narrowed to the output width by wrap or clamp.
  function automatic longint fir_ref(input int hist[$], input int coef[$],
                                     input int nb_out, input int nb_acc);
    longint y;
    longint one;
    longint m;
    y   = 0;
    one = 1;
    for (int k = 0; k < coef.size(); k++) begin
      if (hist.size() > k) begin
        y += longint'(coef[k]) * longint'(hist[hist.size()-1-k]);
      end
    end
    if (nb_out >= nb_acc) begin
      return y;
    end
`ifdef FIR_MAC_SERIAL_SAT_EN
    if (y > (one << (nb_out-1)) - 1) return (one << (nb_out-1)) - 1;
    if (y < -(one << (nb_out-1)))    return -(one << (nb_out-1));
    return y;
`else
    m = y & ((one << nb_out) - 1);
    if (m >= (one << (nb_out-1))) m -= (one << nb_out);
    return m;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus observer: every accepted sample pushes its expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      hist_a.delete();
      exp_a.delete();
      busy_a = -100;
      last_a = 0;
    end else begin
      chk("a_ready", longint'(bus_a.o_ready), (cyc >= busy_a && cyc < busy_a + NA) ? 0 : 1);
      if (bus_a.i_valid && bus_a.o_ready) begin
        hist_a.push_back(int'(bus_a.i_data));
        pa.val = fir_ref(hist_a, ca, OA, ACC_W);
        pa.cyc = cyc + 1 + NA;
        exp_a.push_back(pa);
        busy_a = cyc + 1;
        acc_cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hist_b.delete();
      exp_b.delete();
      busy_b = -100;
      last_b = 0;
    end else begin
      chk("b_ready", longint'(bus_b.o_ready), (cyc >= busy_b && cyc < busy_b + NB) ? 0 : 1);
      if (bus_b.i_valid && bus_b.o_ready) begin
        hist_b.push_back(int'(bus_b.i_data));
        pb.val = fir_ref(hist_b, cb, OB, ACC_W);
        pb.cyc = cyc + 1 + NB;
        exp_b.push_back(pb);
        busy_b = cyc + 1;
      end
    end
  end

  // Output monitors.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.o_valid) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_valid", 1, 0);
        end else begin
          ea = exp_a.pop_front();
          chk("a_data", longint'(bus_a.o_data), ea.val);
          chk("a_latency", cyc, ea.cyc);
          last_a = ea.val;
        end
      end else begin
        chk("a_hold", longint'(bus_a.o_data), last_a);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_b.o_valid) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_valid", 1, 0);
        end else begin
          eb = exp_b.pop_front();
          chk("b_data", longint'(bus_b.o_data), eb.val);
          chk("b_latency", cyc, eb.cyc);
          last_b = eb.val;
        end
      end else begin
        chk("b_hold", longint'(bus_b.o_data), last_b);
      end
    end
  end

  task automatic pack_coeffs();
    for (int k = 0; k < NA; k++) bus_a.i_coeffs[k*8 +: 8] = 8'(ca[k]);
    for (int k = 0; k < NB; k++) bus_b.i_coeffs[k*8 +: 8] = 8'(cb[k]);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int sel, input int d);
    bit got;
    int t;
    got = 1'b0;
    t   = 0;
    if (sel == 0) begin
      bus_a.i_data = 8'(d); bus_a.i_valid = 1'b1;
    end else begin
      bus_b.i_data = 8'(d); bus_b.i_valid = 1'b1;
    end
    while (!got && t < 60) begin
      @(negedge clk);
      got = (sel == 0) ? bus_a.o_ready : bus_b.o_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!got) chk("send_timeout", 0, 1);
    bus_a.i_valid = 1'b0;
    bus_b.i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    chk("drain_pending", exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_a_ready", longint'(bus_a.o_ready), 1);
    chk("rst_a_valid", longint'(bus_a.o_valid), 0);
    chk("rst_a_data",  longint'(bus_a.o_data), 0);
    chk("rst_b_ready", longint'(bus_b.o_ready), 1);
    chk("rst_b_data",  longint'(bus_b.o_data), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ramp;
    int base_cnt;
    bus_a.i_data = '0; bus_a.i_valid = 1'b0;
    bus_b.i_data = '0; bus_b.i_valid = 1'b0;
    for (int k = 0; k < NA; k++) ca.push_back(k + 1);
    for (int k = 0; k < NB; k++) cb.push_back(k + 1);
    pack_coeffs();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state();

    // Impulse response, coefficients 1..8.
    send(0, 1);
    for (int i = 0; i < 8; i++) send(0, 0);
    wait_drain();

    // Full-scale negative inputs and coefficients.
    do_reset();
    for (int k = 0; k < NA; k++) ca[k] = -128;
    pack_coeffs();
    for (int i = 0; i < 8; i++) send(0, -128);
    wait_drain();

    // Backpressure: valid held high with data changing every cycle.
    for (int k = 0; k < NA; k++) ca[k] = k + 1;
    pack_coeffs();
    base_cnt = acc_cnt_a;
    ramp = 0;
    bus_a.i_valid = 1'b1;
    for (int i = 0; i < 90; i++) begin
      bus_a.i_data = 8'(ramp);
      ramp++;
      @(posedge clk); #1;
    end
    bus_a.i_valid = 1'b0;
    chk("bp_accept_count", acc_cnt_a - base_cnt, 10);
    wait_drain();

    // Reset in MAC cycle 4 aborts the result and clears history.
    do_reset();
    send(0, 1);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    check_reset_state();
    send(0, 1);
    for (int i = 0; i < 8; i++) send(0, 0);
    wait_drain();

    // Five-tap instance: random stream past several pointer wraps.
    for (int i = 0; i < 12; i++) send(1, int'($urandom_range(0, 255)) - 128);
    wait_drain();

    // Five-tap instance: positive overflow of the 12-bit output.
    do_reset();
    for (int k = 0; k < NB; k++) cb[k] = 127;
    pack_coeffs();
    for (int i = 0; i < 6; i++) send(1, 127);
    wait_drain();

    // Random coefficients and data on both instances.
    for (int k = 0; k < NA; k++) ca[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < NB; k++) cb[k] = int'($urandom_range(0, 255)) - 128;
    pack_coeffs();
    for (int i = 0; i < 20; i++) begin
      send(0, int'($urandom_range(0, 255)) - 128);
      send(1, int'($urandom_range(0, 255)) - 128);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
